// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, 32-step restoring divider, data SRAM request, EXE->MEM bus
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic        slt_res;
  logic        sltu_res;

  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_res = alu_src1 < alu_src2;
  assign sll_res  = alu_src1 << alu_src2[4:0];
  assign srl_res  = alu_src1 >> alu_src2[4:0];
  assign sra_res  = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

  // one-hot op select: add sub slt sltu and nor or xor sll srl sra lui
  assign alu_result = ({32{alu_op[0]}}  & add_res)
                    | ({32{alu_op[1]}}  & sub_res)
                    | ({32{alu_op[2]}}  & {31'b0, slt_res})
                    | ({32{alu_op[3]}}  & {31'b0, sltu_res})
                    | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                    | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[8]}}  & sll_res)
                    | ({32{alu_op[9]}}  & srl_res)
                    | ({32{alu_op[10]}} & sra_res)
                    | ({32{alu_op[11]}} & alu_src2);
endmodule

module exe_stage #(
  parameter int DS2ES_W = 225,
  parameter int ES2MS_W = 174
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms_allowin,
  output logic               es_allowin,
  input  logic               ds_to_es_valid,
  input  logic [DS2ES_W-1:0] ds_to_es_bus,
  output logic               es_to_ms_valid,
  output logic [ES2MS_W-1:0] es_to_ms_bus,
  output logic [38:0]        es_to_ds_fwd,
  output logic               out_es_valid,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  input  logic               ms_ex,
  input  logic               wb_ex,
  input  logic               wb_ertn
);
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  logic               es_valid;
  logic [DS2ES_W-1:0] bus_r;
  logic               es_ready_go;
  logic               flush;

  logic [3:0]  div_op;
  logic [2:0]  st_op;
  logic [4:0]  ld_op;
  logic [33:0] csr_data;
  logic [11:0] alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] rj_value;
  logic [31:0] rkd_value;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] pc;

  assign {div_op, st_op, ld_op, csr_data, alu_op, src1, src2, rj_value, rkd_value,
          res_from_mem, gr_we, dest, pc} = bus_r;

  assign flush = wb_ex | wb_ertn;

  always_ff @(posedge clk) begin
    if (reset || flush) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) bus_r <= '0;
    else if (ds_to_es_valid && es_allowin) bus_r <= ds_to_es_bus;
  end

  logic [31:0] alu_result;

  alu u_alu (
    .alu_op     (alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  div_state_t  div_state;
  div_state_t  div_next;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [4:0]  cnt;
  logic        is_div;
  logic        div_signed;
  logic [31:0] rj_abs;
  logic [31:0] rkd_abs;
  logic [32:0] step_shift;
  logic [32:0] step_diff;
  logic        step_ge;
  logic [31:0] step_rem;

  assign is_div     = |div_op;
  assign div_signed = div_op[3] | div_op[2];
  assign rj_abs     = (div_signed && rj_value[31])  ? -rj_value  : rj_value;
  assign rkd_abs    = (div_signed && rkd_value[31]) ? -rkd_value : rkd_value;

  // restoring step: bring down the next dividend bit, keep the trial difference if it fits
  assign step_shift = {rem, dvd[31]};
  assign step_diff  = step_shift - {1'b0, dvs};
  assign step_ge    = step_shift >= {1'b0, dvs};
  assign step_rem   = step_ge ? step_diff[31:0] : step_shift[31:0];

  always_ff @(posedge clk) begin
    if (reset) div_state <= DIV_IDLE;
    else div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    if (flush) begin
      div_next = DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: if (es_valid && is_div) div_next = DIV_CALC;
        DIV_CALC: if (cnt == 5'd31) div_next = DIV_DONE;
        DIV_DONE: if (ms_allowin) div_next = DIV_IDLE;
        default:  div_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else if (div_state == DIV_IDLE && div_next == DIV_CALC) begin
      dvd <= rj_abs;
      dvs <= rkd_abs;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else if (div_state == DIV_CALC) begin
      dvd <= {dvd[30:0], 1'b0};
      rem <= step_rem;
      quo <= {quo[30:0], step_ge};
      cnt <= cnt + 5'd1;
    end
  end

  logic        div_zero;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] result;

  assign div_zero  = (rkd_value == 32'd0);
  assign q_neg     = div_signed && (rj_value[31] ^ rkd_value[31]);
  assign r_neg     = div_signed && rj_value[31];
  assign quotient  = div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo : quo);
  assign remainder = div_zero ? rj_value : (r_neg ? -rem : rem);

  assign result = (div_op[3] | div_op[1]) ? quotient
                : (div_op[2] | div_op[0]) ? remainder
                : alu_result;

  assign es_ready_go    = is_div ? (div_state == DIV_DONE) : 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign out_es_valid   = es_valid;

  assign es_to_ms_bus = {rj_value, rkd_value, csr_data, ld_op, res_from_mem, gr_we, dest,
                         result, pc};

  logic fwd_we;
  logic fwd_block;

  assign fwd_we       = es_valid && gr_we;
  assign fwd_block    = fwd_we && (res_from_mem || (is_div && div_state != DIV_DONE));
  assign es_to_ds_fwd = {fwd_we, fwd_block, dest, result};

  logic es_ex;
  logic st_en;

  assign es_ex = csr_data[29];

  // the request fires only in the cycle the instruction leaves, so it is issued exactly once
  assign data_sram_en = es_valid && (|ld_op || |st_op) && es_ready_go && ms_allowin
                     && !es_ex && !ms_ex && !wb_ex && !wb_ertn;
  assign data_sram_addr = alu_result;
  assign st_en          = data_sram_en && |st_op;

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = 32'd0;
    if (st_en) begin
      if (st_op[2]) begin
        data_sram_we    = 4'b0001 << alu_result[1:0];
        data_sram_wdata = {4{rkd_value[7:0]}};
      end else if (st_op[1]) begin
        data_sram_we    = alu_result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rkd_value[15:0]}};
      end else begin
        data_sram_we    = 4'b1111;
        data_sram_wdata = rkd_value;
      end
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - vector table, corner sequences and randomized model check for exe_stage
module tb_exe_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [224:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [173:0] es_to_ms_bus;
  logic [38:0]  es_to_ds_fwd;
  logic         out_es_valid;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ms_ex;
  logic         wb_ex;
  logic         wb_ertn;

  exe_stage #(.DS2ES_W(225), .ES2MS_W(174)) dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_fwd    (es_to_ds_fwd),
    .out_es_valid    (out_es_valid),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ms_ex           (ms_ex),
    .wb_ex           (wb_ex),
    .wb_ertn         (wb_ertn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  div_op;
    logic [2:0]  st_op;
    logic [4:0]  ld_op;
    logic        csr29;
    logic        mse;
    logic [11:0] alu_op;
    logic [31:0] s1, s2, rj, rkd;
    logic [31:0] exp_res;
    int          exp_lat;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic [3:0] d, input logic [2:0] s,
      input logic [4:0] l, input logic c29, input logic me, input logic [11:0] a,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rj, input logic [31:0] rkd,
      input logic [31:0] res, input int lat, input logic en, input logic [3:0] we, input logic [31:0] wd);
    vec_t v;
    v.name = nm; v.div_op = d; v.st_op = s; v.ld_op = l; v.csr29 = c29; v.mse = me;
    v.alu_op = a; v.s1 = s1; v.s2 = s2; v.rj = rj; v.rkd = rkd;
    v.exp_res = res; v.exp_lat = lat; v.exp_en = en; v.exp_we = we; v.exp_wd = wd;
    return v;
  endfunction

  function automatic logic [224:0] mk_bus(input logic [3:0] d, input logic [2:0] s,
      input logic [4:0] l, input logic c29, input logic [11:0] a, input logic [31:0] s1,
      input logic [31:0] s2, input logic [31:0] rj, input logic [31:0] rkd,
      input logic [4:0] dest, input logic [31:0] pc);
    logic [33:0] csr;
    csr = {4'b0, c29, 29'b0};
    return {d, s, l, csr, a, s1, s2, rj, rkd, |l, 1'b1, dest, pc};
  endfunction

  // reference model: architectural meaning of each operation, plain arithmetic
  function automatic void model(input logic [3:0] d, input logic [2:0] s, input logic [11:0] a,
      input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rj, input logic [31:0] rkd,
      output logic [31:0] res, output logic [3:0] we, output logic [31:0] wd);
    longint sa, sd;
    int size, base;
    res = 32'd0; we = 4'd0; wd = 32'd0;
    for (int k = 0; k < 12; k++) begin
      if (a[k]) begin
        case (k)
          0: res = s1 + s2;
          1: res = s1 - s2;
          2: res = ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
          3: res = (s1 < s2) ? 32'd1 : 32'd0;
          4: res = s1 & s2;
          5: res = ~(s1 | s2);
          6: res = s1 | s2;
          7: res = s1 ^ s2;
          8: res = s1 << s2[4:0];
          9: res = s1 >> s2[4:0];
          10: res = $unsigned($signed(s1) >>> s2[4:0]);
          default: res = s2;
        endcase
      end
    end
    if (d != 4'd0) begin
      sa = longint'($signed(rj));
      sd = longint'($signed(rkd));
      if (rkd == 32'd0) res = (d[3] | d[1]) ? 32'hFFFF_FFFF : rj;
      else if (d[3]) res = 32'(sa / sd);
      else if (d[2]) res = 32'(sa % sd);
      else if (d[1]) res = rj / rkd;
      else res = rj % rkd;
    end
    if (s != 3'd0) begin
      size = s[2] ? 1 : (s[1] ? 2 : 4);
      base = (int'(res[1:0]) / size) * size;
      for (int i = 0; i < 4; i++) begin
        if (i >= base && i < base + size) we[i] = 1'b1;
        wd[8*i +: 8] = rkd[8*(i % size) +: 8];
      end
    end
  endfunction

  task automatic send(input logic [224:0] b, input logic mse, input bit stall,
      output logic [173:0] obus, output int lat, output int en_cnt, output logic [3:0] we,
      output logic [31:0] wd, output logic [38:0] fwd0, output bit ok);
    ok = 0; lat = -1; en_cnt = 0; we = 4'd0; wd = 32'd0; obus = '0; fwd0 = '0;
    @(negedge clk);
    ms_ex = mse; ms_allowin = 1'b1; ds_to_es_valid = 1'b1; ds_to_es_bus = b;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (stall) ms_allowin = ($urandom_range(0, 3) != 0);
      #1;
      if (n == 0) fwd0 = es_to_ds_fwd;
      if (es_to_ms_valid && lat < 0) lat = n;
      if (data_sram_en) begin
        en_cnt++;
        we = data_sram_we;
        wd = data_sram_wdata;
      end
      if (es_to_ms_valid && ms_allowin) begin
        obus = es_to_ms_bus;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    ms_allowin = 1'b1; ms_ex = 1'b0;
    #1;
    if (data_sram_en) en_cnt++;
  endtask

  vec_t tbl[$];

  initial begin
    logic [224:0] b;
    logic [173:0] obus;
    logic [38:0]  fwd0;
    logic [3:0]   we, ewe;
    logic [31:0]  wd, ewd, eres, pc;
    logic [4:0]   dest;
    int lat, en_cnt, seen, elat;
    bit ok;
    vec_t v;

    reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    ms_ex = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.es_valid", out_es_valid, 1'b0);
    chk("rst.to_ms_valid", es_to_ms_valid, 1'b0);
    chk("rst.allowin", es_allowin, 1'b1);
    chk("rst.sram_en", data_sram_en, 1'b0);
    chk("rst.sram_we", data_sram_we, 4'd0);
    reset = 1'b0;

    tbl.push_back(mkv("add",   0, 0, 0, 0, 0, 12'h001, 32'd5, 32'd7, 0, 0, 32'hC, 0, 0, 0, 0));
    tbl.push_back(mkv("sub",   0, 0, 0, 0, 0, 12'h002, 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0));
    tbl.push_back(mkv("sltu",  0, 0, 0, 0, 0, 12'h008, 32'd1, 32'hFFFF_FFFF, 0, 0, 32'd1, 0, 0, 0, 0));
    tbl.push_back(mkv("slt",   0, 0, 0, 0, 0, 12'h004, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 0, 0, 0, 0));
    tbl.push_back(mkv("sra",   0, 0, 0, 0, 0, 12'h400, 32'h8000_0000, 32'd4, 0, 0, 32'hF800_0000, 0, 0, 0, 0));
    tbl.push_back(mkv("st_b",  0, 3'b100, 0, 0, 0, 12'h001, 32'h1000, 32'd3, 0, 32'hAB, 32'h1003, 0, 1, 4'b1000, 32'hABAB_ABAB));
    tbl.push_back(mkv("st_h_hi", 0, 3'b010, 0, 0, 0, 12'h001, 32'h1000, 32'd2, 0, 32'h1234_BEEF, 32'h1002, 0, 1, 4'b1100, 32'hBEEF_BEEF));
    tbl.push_back(mkv("st_h_lo", 0, 3'b010, 0, 0, 0, 12'h001, 32'h1000, 32'd0, 0, 32'h0000_5A5A, 32'h1000, 0, 1, 4'b0011, 32'h5A5A_5A5A));
    tbl.push_back(mkv("st_w",  0, 3'b001, 0, 0, 0, 12'h001, 32'h2000, 32'd0, 0, 32'hDEAD_BEEF, 32'h2000, 0, 1, 4'b1111, 32'hDEAD_BEEF));
    tbl.push_back(mkv("ld_w",  0, 0, 5'b10000, 0, 0, 12'h001, 32'h3000, 32'd4, 0, 32'h5555_5555, 32'h3004, 0, 1, 0, 0));
    tbl.push_back(mkv("st_w_msex", 0, 3'b001, 0, 0, 1, 12'h001, 32'h2000, 32'd8, 0, 32'h1111_2222, 32'h2008, 0, 0, 0, 0));
    tbl.push_back(mkv("st_w_esex", 0, 3'b001, 0, 1, 0, 12'h001, 32'h2000, 32'd12, 0, 32'h3333_4444, 32'h200C, 0, 0, 0, 0));
    tbl.push_back(mkv("div_w",  4'b1000, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 0, 0));
    tbl.push_back(mkv("mod_w",  4'b0100, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 0, 0));
    tbl.push_back(mkv("div_wu", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 0, 0, 0));
    tbl.push_back(mkv("div_w_z", 4'b1000, 0, 0, 0, 0, 0, 0, 0, 32'h64, 32'd0, 32'hFFFF_FFFF, 33, 0, 0, 0));
    tbl.push_back(mkv("mod_wu_z", 4'b0001, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'd0, 32'h1234_5678, 33, 0, 0, 0));
    tbl.push_back(mkv("div_w_ovf", 4'b1000, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0, 0, 0));
    tbl.push_back(mkv("mod_w_ovf", 4'b0100, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0, 0, 0));
    tbl.push_back(mkv("mod_w_pn", 4'b0100, 0, 0, 0, 0, 0, 0, 0, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, 0, 0));
    tbl.push_back(mkv("div_w_pn", 4'b1000, 0, 0, 0, 0, 0, 0, 0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0, 0, 0));
    tbl.push_back(mkv("mod_w_z", 4'b0100, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 33, 0, 0, 0));
    tbl.push_back(mkv("mod_wu", 4'b0001, 0, 0, 0, 0, 0, 0, 0, 32'd100, 32'd7, 32'd2, 33, 0, 0, 0));
    tbl.push_back(mkv("div_wu_b", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33, 0, 0, 0));

    foreach (tbl[i]) begin
      v = tbl[i];
      dest = 5'(i + 1);
      pc = 32'h1C00_0000 + 32'(i * 4);
      b = mk_bus(v.div_op, v.st_op, v.ld_op, v.csr29, v.alu_op, v.s1, v.s2, v.rj, v.rkd, dest, pc);
      send(b, v.mse, 1'b0, obus, lat, en_cnt, we, wd, fwd0, ok);
      chk({v.name, ".done"}, ok, 1'b1);
      chk({v.name, ".lat"}, lat, v.exp_lat);
      chk({v.name, ".bus"}, obus, {v.rj, v.rkd, 4'b0, v.csr29, 29'b0, v.ld_op, |v.ld_op, 1'b1,
                                   dest, v.exp_res, pc});
      chk({v.name, ".en_cnt"}, en_cnt, v.exp_en ? 1 : 0);
      chk({v.name, ".we"}, we, v.exp_we);
      chk({v.name, ".wdata"}, wd, v.exp_wd);
      chk({v.name, ".fwd"}, fwd0[38:32], {1'b1, (|v.ld_op) || (|v.div_op), dest});
    end

    // divide finishes while MEM is stalled; the next instruction follows in the release cycle
    @(negedge clk);
    ms_allowin = 1'b0; ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk_bus(4'b1000, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h100);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    seen = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (es_to_ms_valid) begin seen = n; break; end
      @(negedge clk);
    end
    chk("stall.lat", seen, 33);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk_bus(0, 0, 0, 0, 12'h001, 32'd3, 32'd4, 0, 0, 5'd4, 32'h104);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("stall.valid%0d", n), es_to_ms_valid, 1'b1);
      chk($sformatf("stall.res%0d", n), es_to_ms_bus[63:32], 32'hFFFF_FFFD);
      chk($sformatf("stall.allowin%0d", n), es_allowin, 1'b0);
      chk($sformatf("stall.block%0d", n), es_to_ds_fwd[37], 1'b0);
      @(negedge clk);
    end
    ms_allowin = 1'b1;
    #1;
    chk("stall.release_allowin", es_allowin, 1'b1);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    #1;
    chk("stall.next_valid", es_to_ms_valid, 1'b1);
    chk("stall.next_res", es_to_ms_bus[63:32], 32'd7);
    chk("stall.next_pc", es_to_ms_bus[31:0], 32'h104);
    @(negedge clk);

    // exception flush part-way through a divide
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk_bus(4'b1000, 0, 0, 0, 0, 0, 0, 32'd1000, 32'd7, 5'd5, 32'h200);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    repeat (11) @(negedge clk);
    wb_ex = 1'b1;
    @(negedge clk);
    wb_ex = 1'b0;
    #1;
    chk("flush.es_valid", out_es_valid, 1'b0);
    chk("flush.allowin", es_allowin, 1'b1);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (es_to_ms_valid) seen++;
      @(negedge clk);
      #1;
    end
    chk("flush.no_valid", seen, 0);
    b = mk_bus(4'b0010, 0, 0, 0, 0, 0, 0, 32'd1000, 32'd7, 5'd6, 32'h204);
    send(b, 1'b0, 1'b0, obus, lat, en_cnt, we, wd, fwd0, ok);
    chk("flush.restart_lat", lat, 33);
    chk("flush.restart_res", obus[63:32], 32'd142);

    // load held back by MEM back-pressure issues exactly one request
    @(negedge clk);
    ms_allowin = 1'b0; ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk_bus(0, 0, 5'b10000, 0, 12'h001, 32'h4000, 32'd0, 0, 0, 5'd7, 32'h300);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      #1;
      if (data_sram_en) seen++;
      @(negedge clk);
    end
    chk("ldstall.held", seen, 0);
    ms_allowin = 1'b1;
    #1;
    chk("ldstall.en", data_sram_en, 1'b1);
    chk("ldstall.addr", data_sram_addr, 32'h4000);
    @(negedge clk);
    #1;
    chk("ldstall.once", data_sram_en, 1'b0);

    // randomized instructions against the model, with random MEM back-pressure
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [3:0] d; logic [2:0] s; logic [4:0] l; logic [11:0] a;
      logic [31:0] s1, s2, rj, rkd;
      logic c29, me, een;
      d = 0; s = 0; l = 0; a = 0; c29 = 0; me = 0;
      s1 = $urandom; s2 = $urandom; rj = $urandom; rkd = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        0: a = 12'(1) << $urandom_range(0, 11);
        1: begin
          d = 4'(1) << $urandom_range(0, 3);
          case ($urandom_range(0, 5))
            0: rkd = 32'd0;
            1: rkd = 32'hFFFF_FFFF;
            2: rkd = 32'($urandom_range(1, 20));
            3: rj = 32'h8000_0000;
            default: ;
          endcase
        end
        2: begin
          s = 3'(1) << $urandom_range(0, 2);
          a = 12'h001; s2 = 32'($urandom_range(0, 255));
          c29 = ($urandom_range(0, 7) == 0); me = ($urandom_range(0, 3) == 0);
        end
        default: begin
          l = 5'(1) << $urandom_range(0, 4);
          a = 12'h001; s2 = 32'($urandom_range(0, 255));
          c29 = ($urandom_range(0, 7) == 0); me = ($urandom_range(0, 3) == 0);
        end
      endcase
      model(d, s, a, s1, s2, rj, rkd, eres, ewe, ewd);
      een = ((s != 0) || (l != 0)) && !c29 && !me;
      if (!een) begin ewe = 4'd0; ewd = 32'd0; end
      elat = (d != 0) ? 33 : 0;
      b = mk_bus(d, s, l, c29, a, s1, s2, rj, rkd, 5'(i), 32'h8000_0000 + 32'(i * 4));
      send(b, me, 1'b1, obus, lat, en_cnt, we, wd, fwd0, ok);
      chk($sformatf("rnd%0d.done", i), ok, 1'b1);
      chk($sformatf("rnd%0d.res", i), obus[63:32], eres);
      chk($sformatf("rnd%0d.lat", i), lat, elat);
      chk($sformatf("rnd%0d.en_cnt", i), en_cnt, een ? 1 : 0);
      chk($sformatf("rnd%0d.we", i), we, ewe);
      chk($sformatf("rnd%0d.wdata", i), wd, ewd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
